// File: rtl/mult4s_shared_arbiter_if.sv
// mult4s_shared_arbiter_if: request/response bus between the requesters and the shared multiplier.
interface mult4s_shared_arbiter_if #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
);
   logic [NUM_REQ-1:0]   req_valid;
   logic [NUM_REQ-1:0]   req_ready;
   logic [4*NUM_REQ-1:0] req_multiplicand;
   logic [4*NUM_REQ-1:0] req_multiplier;
   logic                 rsp_valid;
   logic                 rsp_ready;
   logic [7:0]           rsp_product;
   logic [ID_W-1:0]      rsp_id;
   modport master (
      output req_valid, req_multiplicand, req_multiplier, rsp_ready,
      input  req_ready, rsp_valid, rsp_product, rsp_id
   );
   modport slave (
      input  req_valid, req_multiplicand, req_multiplier, rsp_ready,
      output req_ready, rsp_valid, rsp_product, rsp_id
   );
endinterface

// File: rtl/mult4s_shared_arbiter.sv
// mult4s_shared_arbiter: NUM_REQ requesters share one two-stage signed 4x4 multiplier.
// MULT4S_ARB_ROUND_ROBIN_EN selects round-robin arbitration; undefined gives fixed priority.
module mult4s_normal_ripple (
   input  logic [3:0] i_a,
   input  logic [3:0] i_b,
   output logic [7:0] o_p
);
   function automatic logic [7:0] f_ripple(input logic [7:0] x, input logic [7:0] y, input logic ci);
      logic [7:0] s;
      logic       c;
      s = '0;
      c = ci;
      for (int k = 0; k < 8; k++) begin
         s[k] = x[k] ^ y[k] ^ c;
         c    = (x[k] & y[k]) | (c & (x[k] ^ y[k]));
      end
      return s;
   endfunction
   logic [7:0] w_a;
   logic [7:0] w_pp;
   logic [7:0] w_acc;
   assign w_a = {{4{i_a[3]}}, i_a};
   always_comb begin
      w_pp  = '0;
      w_acc = '0;
      for (int j = 0; j < 4; j++) begin
         w_pp  = i_b[j] ? w_a << j : '0;
         // B's sign bit carries weight -8, so its row is subtracted
         w_acc = j == 3 ? f_ripple(w_acc, ~w_pp, 1'b1) : f_ripple(w_acc, w_pp, 1'b0);
      end
   end
   assign o_p = w_acc;
endmodule

module mult4s_shared_arbiter #(
   parameter int NUM_REQ = 4,
   parameter int ID_W    = 2
) (
   input logic                    clk,
   input logic                    rst,
   mult4s_shared_arbiter_if.slave bus
);
   logic               r_s1_valid;
   logic               r_s2_valid;
   logic               r_init;
   logic [ID_W-1:0]    r_s1_id;
   logic [ID_W-1:0]    r_s2_id;
   logic [3:0]         r_s1_a;
   logic [3:0]         r_s1_b;
   logic [7:0]         r_s2_p;
   logic [NUM_REQ-1:0] w_grant;
   logic [ID_W-1:0]    w_id;
   logic [3:0]         w_a;
   logic [3:0]         w_b;
   logic [7:0]         w_prod;
   logic               w_s2_adv;
   logic               w_s1_adv;
   logic               w_s1_load;
   logic               w_acc_en;
   logic               w_xfer;

   assign w_s2_adv  = !r_s2_valid || bus.rsp_ready;
   assign w_s1_adv  = r_s1_valid && w_s2_adv;
   assign w_s1_load = !r_s1_valid || w_s1_adv;
   // r_init keeps req_ready low for the whole cycle following a reset edge
   assign w_acc_en  = w_s1_load && !rst && !r_init;
   assign bus.req_ready = w_acc_en ? w_grant : '0;
   assign w_xfer    = |bus.req_ready;

`ifdef MULT4S_ARB_ROUND_ROBIN_EN
   logic [ID_W-1:0] r_ptr;
   logic            w_hit;
   always_comb begin
      w_grant = '0;
      w_hit   = 1'b0;
      for (int i = 0; i < NUM_REQ; i++)
         if (!w_hit && bus.req_valid[i] && ID_W'(i) >= r_ptr) begin
            w_grant[i] = 1'b1;
            w_hit      = 1'b1;
         end
      for (int i = 0; i < NUM_REQ; i++)
         if (!w_hit && bus.req_valid[i]) begin
            w_grant[i] = 1'b1;
            w_hit      = 1'b1;
         end
   end
   always_ff @(posedge clk)
      if (rst) r_ptr <= '0;
      else if (w_xfer) r_ptr <= w_id == ID_W'(NUM_REQ - 1) ? '0 : w_id + ID_W'(1);
`else
   assign w_grant = bus.req_valid & (~bus.req_valid + NUM_REQ'(1));
`endif

   always_comb begin
      w_id = '0;
      w_a  = '0;
      w_b  = '0;
      for (int i = 0; i < NUM_REQ; i++)
         if (w_grant[i]) begin
            w_id = ID_W'(i);
            w_a  = bus.req_multiplicand[4*i +: 4];
            w_b  = bus.req_multiplier[4*i +: 4];
         end
   end

   mult4s_normal_ripple u_mul (.i_a(r_s1_a), .i_b(r_s1_b), .o_p(w_prod));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_s1_valid <= 1'b0;
         r_s2_valid <= 1'b0;
         r_init     <= 1'b1;
      end else begin
         r_init <= 1'b0;
         if (w_s2_adv) r_s2_valid <= r_s1_valid;
         if (w_s1_load) r_s1_valid <= w_xfer;
      end
   end

   always_ff @(posedge clk) begin
      if (w_xfer) begin
         r_s1_id <= w_id;
         r_s1_a  <= w_a;
         r_s1_b  <= w_b;
      end
      if (w_s2_adv) begin
         r_s2_id <= r_s1_id;
         r_s2_p  <= w_prod;
      end
   end

   assign bus.rsp_valid   = r_s2_valid;
   assign bus.rsp_product = r_s2_p;
   assign bus.rsp_id      = r_s2_id;
endmodule

// File: tb/tb_mult4s_shared_arbiter.sv
// tb_mult4s_shared_arbiter: table vectors plus scoreboard for the shared multiplier arbiter.
module tb_mult4s_shared_arbiter;
   localparam int NR = 4;
   typedef struct {
      int         id;
      logic [3:0] a;
      logic [3:0] b;
      logic [7:0] p;
   } vec_t;
   typedef struct {
      logic [7:0] p;
      logic [1:0] id;
   } exp_t;

   logic          clk = 1'b0;
   logic          rst;
   int            n_vec = 0;
   int            n_err = 0;
   exp_t          sb[$];
   vec_t          tv[9];
   logic [NR-1:0] p_stall = '0;
   logic [15:0]   p_a;
   logic [15:0]   p_b;

   mult4s_shared_arbiter_if #(.NUM_REQ(NR), .ID_W(2)) bus ();
   mult4s_shared_arbiter #(.NUM_REQ(NR), .ID_W(2)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   // a waiting requester must hold its operands
   always @(posedge clk) begin
      for (int i = 0; i < NR; i++)
         if (!rst && p_stall[i] && bus.req_valid[i])
            assert ({bus.req_multiplicand[4*i +: 4], bus.req_multiplier[4*i +: 4]} == {p_a[4*i +: 4], p_b[4*i +: 4]})
            else $error("requester %0d changed operands while waiting", i);
      p_stall <= bus.req_valid & ~bus.req_ready;
      p_a     <= bus.req_multiplicand;
      p_b     <= bus.req_multiplier;
   end

   function automatic logic [7:0] mul(input logic [3:0] a, input logic [3:0] b);
      logic signed [7:0] x;
      logic signed [7:0] y;
      x = {{4{a[3]}}, a};
      y = {{4{b[3]}}, b};
      return 8'(x * y);
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %0h, want %0h", nm, act, exp);
      end
   endtask

   task automatic to_neg();
      exp_t e;
      @(negedge clk);
      if (bus.rsp_valid && bus.rsp_ready) begin
         chk("sb_nonempty", 16'(sb.size() != 0), 16'd1);
         if (sb.size() != 0) begin
            e = sb.pop_front();
            chk("sb_product", bus.rsp_product, e.p);
            chk("sb_id", bus.rsp_id, e.id);
         end
      end
      chk("ready_onehot", 16'($countones(bus.req_ready) <= 1), 16'd1);
      for (int i = 0; i < NR; i++)
         if (bus.req_valid[i] && bus.req_ready[i])
            sb.push_back('{p: mul(bus.req_multiplicand[4*i +: 4], bus.req_multiplier[4*i +: 4]), id: 2'(i)});
   endtask

   task automatic to_pos();
      @(posedge clk);
      #1;
   endtask

   task automatic tick();
      to_neg();
      to_pos();
   endtask

   task automatic set_op(input int i, input logic [3:0] a, input logic [3:0] b);
      bus.req_multiplicand[4*i +: 4] = a;
      bus.req_multiplier[4*i +: 4]   = b;
   endtask

   task automatic do_reset();
      rst           = 1'b1;
      bus.req_valid = '0;
      bus.rsp_ready = 1'b1;
      tick();
      rst = 1'b0;
      sb.delete();
      tick();
   endtask

   initial begin
      tv = '{'{0, 4'd7, 4'h8, 8'hC8}, '{3, 4'h8, 4'h8, 8'h40}, '{2, 4'hF, 4'd1, 8'hFF},
             '{1, 4'd7, 4'd7, 8'h31}, '{0, 4'h8, 4'd7, 8'hC8}, '{3, 4'd0, 4'hB, 8'h00},
             '{1, 4'hD, 4'd5, 8'hF1}, '{2, 4'h9, 4'hF, 8'h07}, '{0, 4'd3, 4'hE, 8'hFA}};
      rst                  = 1'b1;
      bus.rsp_ready        = 1'b1;
      bus.req_valid        = '1;
      bus.req_multiplicand = 16'h4321;
      bus.req_multiplier   = 16'h1111;
      to_pos();
      to_neg();
      chk("rst_ready", bus.req_ready, 16'd0);
      to_pos();
      rst = 1'b0;
      to_neg();
      chk("post_rst_ready", bus.req_ready, 16'd0);
      chk("post_rst_rsp_valid", bus.rsp_valid, 16'd0);
      to_pos();

`ifdef MULT4S_ARB_ROUND_ROBIN_EN
      for (int n = 0; n < 8; n++) begin
         to_neg();
         chk("rr_grant", bus.req_ready, 16'(1 << (n % 4)));
         to_pos();
      end
`else
      bus.req_valid = 4'b1010;
      for (int n = 0; n < 3; n++) begin
         to_neg();
         chk("fixed_grant", bus.req_ready, 16'b0010);
         to_pos();
      end
`endif
      bus.req_valid = '0;
      repeat (3) tick();

      for (int v = 0; v < 9; v++) begin
         set_op(tv[v].id, tv[v].a, tv[v].b);
         bus.req_valid = 4'(1 << tv[v].id);
         to_neg();
         chk("tv_ready", bus.req_ready, 16'(1 << tv[v].id));
         to_pos();
         bus.req_valid = '0;
         to_neg();
         chk("tv_early", bus.rsp_valid, 16'd0);
         to_pos();
         to_neg();
         chk("tv_valid", bus.rsp_valid, 16'd1);
         chk("tv_product", bus.rsp_product, tv[v].p);
         chk("tv_id", bus.rsp_id, 16'(tv[v].id));
         to_pos();
      end

      do_reset();
      set_op(1, 4'h8, 4'h8);
      set_op(2, 4'hF, 4'h1);
      bus.req_valid = 4'b0110;
      to_neg();
      chk("b2b_ready0", bus.req_ready, 16'b0010);
      to_pos();
      bus.req_valid = 4'b0100;
      to_neg();
      chk("b2b_ready1", bus.req_ready, 16'b0100);
      to_pos();
      bus.req_valid = '0;
      to_neg();
      chk("b2b_v0", bus.rsp_valid, 16'd1);
      chk("b2b_p0", bus.rsp_product, 16'h40);
      chk("b2b_id0", bus.rsp_id, 16'd1);
      to_pos();
      to_neg();
      chk("b2b_v1", bus.rsp_valid, 16'd1);
      chk("b2b_p1", bus.rsp_product, 16'hFF);
      chk("b2b_id1", bus.rsp_id, 16'd2);
      to_pos();

      do_reset();
      set_op(0, 4'd3, 4'd5);
      set_op(1, 4'hC, 4'd2);
      set_op(2, 4'd6, 4'hA);
      set_op(3, 4'h8, 4'd1);
      bus.rsp_ready = 1'b0;
      bus.req_valid = '1;
      for (int c = 0; c < 5; c++) begin
         to_neg();
         if (c >= 2) begin
            chk("stall_ready", bus.req_ready, 16'd0);
            chk("stall_valid", bus.rsp_valid, 16'd1);
            chk("stall_product", bus.rsp_product, sb[0].p);
            chk("stall_id", bus.rsp_id, sb[0].id);
         end
         to_pos();
      end
      chk("stall_buffered", 16'(sb.size()), 16'd2);
      bus.req_valid = '0;
      bus.rsp_ready = 1'b1;
      to_neg();
      chk("drain_v0", bus.rsp_valid, 16'd1);
      to_pos();
      to_neg();
      chk("drain_v1", bus.rsp_valid, 16'd1);
      to_pos();
      to_neg();
      chk("drain_empty", bus.rsp_valid, 16'd0);
      chk("drain_sb", 16'(sb.size()), 16'd0);
      to_pos();

      do_reset();
      set_op(0, 4'd6, 4'd2);
      bus.rsp_ready = 1'b0;
      bus.req_valid = 4'b0001;
      tick();
      tick();
      bus.req_valid = '0;
      rst           = 1'b1;
      to_neg();
      chk("mid_rst_ready", bus.req_ready, 16'd0);
      chk("mid_rst_full", bus.rsp_valid, 16'd1);
      to_pos();
      rst           = 1'b0;
      bus.rsp_ready = 1'b1;
      sb.delete();
      set_op(0, 4'd5, 4'hD);
      bus.req_valid = '1;
      to_neg();
      chk("mid_post_valid", bus.rsp_valid, 16'd0);
      chk("mid_post_ready", bus.req_ready, 16'd0);
      to_pos();
      to_neg();
      chk("mid_ptr0_grant", bus.req_ready, 16'b0001);
      to_pos();
      bus.req_valid = '0;
      to_neg();
      chk("mid_gap", bus.rsp_valid, 16'd0);
      to_pos();
      to_neg();
      chk("mid_next_valid", bus.rsp_valid, 16'd1);
      chk("mid_next_product", bus.rsp_product, 16'hF1);
      chk("mid_next_id", bus.rsp_id, 16'd0);
      to_pos();
      to_neg();
      chk("mid_done_valid", bus.rsp_valid, 16'd0);
      chk("mid_done_sb", 16'(sb.size()), 16'd0);
      to_pos();

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
